keypad_lock_fsm: RTL
====================

Name: keypad_lock_fsm

Overview:
- Parametrised combination lock; next generation of the single-password binary lock.
- Supports multi-bit keypad digits, configurable code length, edge-detected key entry, explicit code-length checking, a failed-attempt counter and a timed lockout.
- Sits between the debounced pushbutton decode in top and the seven-segment/LED display logic.
- Display encoding stays outside this block.

Parameters:
- PW_LEN, 6, number of digits in the code.
- DIGIT_W, 4, bits per digit (key_code width).
- MAX_FAILS, 3, consecutive wrong codes that trigger lockout (>=1).
- LOCKOUT_TICKS, 1000, hz100 cycles spent in lockout (10 s).

Ports:
- hz100  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- key_press  in  1  level; a digit is accepted on its rising edge.
- key_code  in  DIGIT_W  digit value, sampled on the same cycle as the detected edge.
- lock_cmd  in  1  level; arm the lock.
- clear_cmd  in  1  level; discard the digits entered so far.
- mode  out  2  current mode_t.
- disp_digits  out  PW_LEN*DIGIT_W  shown digits; digit 0 (LSBs) is the most recent.
- digit_count  out  $clog2(PW_LEN+1)  number of valid digits in the shown buffer.
- fail_count  out  $clog2(MAX_FAILS+1)  consecutive failures.
- lockout_left  out  $clog2(LOCKOUT_TICKS+1)  remaining lockout cycles.
- unlock_pulse  out  1  one-cycle strobe on a correct code.
- red  out  1  high when mode != EDIT.
- green  out  1  high when mode == EDIT.

Behaviour:
- Reset values:
  - mode=EDIT; password, entry buffer, both digit counts, fail_count, lockout_left and unlock_pulse all 0.
  - key_q=0; green=1; red=0.
- Key edge detection: key_q <= key_press. key_evt = key_press & ~key_q. A held key produces exactly one event.
- Shift rule: on an accepted digit, buf <= {buf[(PW_LEN-1)*DIGIT_W-1:0], key_code}. The count increments, saturating at PW_LEN.
- Command priority per cycle: lock_cmd > clear_cmd > key_evt. A lower-priority event in the same cycle is dropped.
- EDIT:
  - key_evt shifts into password. In EDIT, disp_digits shows the password.
  - clear_cmd zeroes password and pw_count.
  - lock_cmd with pw_count==PW_LEN: go to LOCKED; clear the entry buffer and entry count. fail_count is retained.
  - lock_cmd with pw_count<PW_LEN: ignored, stay in EDIT.
- LOCKED:
  - key_evt shifts into the entry buffer. In LOCKED and CHECK, disp_digits shows the entry buffer.
  - The accepted digit that makes the entry count reach PW_LEN moves the FSM to CHECK on the same edge.
  - clear_cmd zeroes the entry buffer and entry count. fail_count is unchanged.
  - lock_cmd is a no-op.
- CHECK (exactly one cycle; all inputs ignored):
  - Match: go to EDIT; unlock_pulse=1 for this one transition cycle; fail_count<=0; clear the entry buffer. The password is retained.
  - Mismatch with fail_count+1 < MAX_FAILS: fail_count++; return to LOCKED with the entry buffer cleared.
  - Mismatch with fail_count+1 == MAX_FAILS: fail_count<=MAX_FAILS; go to LOCKOUT; lockout_left<=LOCKOUT_TICKS.
- LOCKOUT:
  - All key and command inputs are ignored. disp_digits=0 and digit_count=0.
  - lockout_left decrements every cycle.
  - On the cycle lockout_left==1: go to LOCKED; lockout_left<=0; fail_count<=0; entry buffer cleared.
- Latency:
  - A correct code is detected 1 cycle after the final key edge is registered, i.e. unlock_pulse is high 2 cycles after key_press rises.
- Asynchronous reset mid-operation (any state, including LOCKOUT) immediately restores all reset values. The password is lost.
- All counters saturate. None wraps.

Decomposition:
- Package lock_pkg holds:
  - typedef enum logic [1:0] mode_t {EDIT=2'd0, LOCKED=2'd1, CHECK=2'd2, LOCKOUT=2'd3};
  - the localparam width helpers (count, fail and timer widths via $clog2).
- Sub-module lock_shreg (parameters PW_LEN, DIGIT_W):
  - Ports: hz100, reset, shift, clear, din, q, count.
  - Implements the saturating-count digit shift register.
  - Instantiated twice: once for the password, once for the entry buffer.
- The FSM, edge detector, fail counter and lockout timer stay in keypad_lock_fsm.

Test Plan:
Bench parameters: PW_LEN=4, DIGIT_W=4, MAX_FAILS=2, LOCKOUT_TICKS=5.
- Enter keys 3,A,0,7 in EDIT, then lock_cmd -> mode=LOCKED, disp_digits=0, digit_count=0; password internal value 16'h3A07.
- Enter 3,A,0,7 while LOCKED -> CHECK for 1 cycle, then unlock_pulse=1 for exactly 1 cycle, mode=EDIT, fail_count=0, green=1.
- Enter 3,A,0,8, then 1,1,1,1 -> fail_count=1 after the first code. After the second: mode=LOCKOUT, lockout_left=5, counting down to LOCKED after 5 cycles with fail_count=0. Keys during lockout are ignored.
- Hold key_press high for 20 cycles with key_code=5 -> exactly one digit accepted (digit_count=1). lock_cmd in EDIT with pw_count=2 -> mode stays EDIT.
- In LOCKED, enter 3,A then raise clear_cmd and key_press on the same cycle -> entry buffer=0, digit_count=0, key dropped. Assert lock_cmd+key together in EDIT with a full password -> mode=LOCKED, password unchanged.
- Assert reset during LOCKOUT with lockout_left=3 -> asynchronously: mode=EDIT, lockout_left=0, fail_count=0, password=0, red=0, green=1.

Source files
------------

// File: rtl/lock_pkg.sv
// Shared types and width helpers for the keypad combination lock.
package lock_pkg;

    typedef enum logic [1:0] {
        EDIT    = 2'd0,
        LOCKED  = 2'd1,
        CHECK   = 2'd2,
        LOCKOUT = 2'd3
    } mode_t;

    // Default build of the lock (6-digit hex code, 3 tries, 10 s at 100 Hz).
    localparam int DEF_PW_LEN        = 6;
    localparam int DEF_DIGIT_W       = 4;
    localparam int DEF_MAX_FAILS     = 3;
    localparam int DEF_LOCKOUT_TICKS = 1000;

    // Bits needed to hold a count from 0 up to and including n.
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    // Digit counter width for a code of pw_len digits.
    function automatic int digit_cnt_w(input int pw_len);
        return cnt_w(pw_len);
    endfunction

    // Failed-attempt counter width.
    function automatic int fail_w(input int max_fails);
        return cnt_w(max_fails);
    endfunction

    // Lockout timer width.
    function automatic int timer_w(input int ticks);
        return cnt_w(ticks);
    endfunction

endpackage

// File: rtl/lock_shreg.sv
// Digit shift register with a saturating fill count. New digits enter at
// the LSB end, so digit 0 is always the most recently accepted one.
module lock_shreg
    import lock_pkg::*;
#(
    parameter int PW_LEN  = DEF_PW_LEN,
    parameter int DIGIT_W = DEF_DIGIT_W
) (
    input  logic                             hz100,
    input  logic                             reset,
    input  logic                             shift,
    input  logic                             clear,
    input  logic [DIGIT_W-1:0]               din,
    output logic [PW_LEN*DIGIT_W-1:0]        q,
    output logic [digit_cnt_w(PW_LEN)-1:0]   count
);

    localparam int BUF_W = PW_LEN * DIGIT_W;
    localparam int CNT_W = digit_cnt_w(PW_LEN);

    logic [BUF_W-1:0] sr_q, sr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next buffer/count: clear wins over shift; count stops at PW_LEN.
    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (clear) begin
            sr_d  = '0;
            cnt_d = '0;
        end else if (shift) begin
            sr_d = (sr_q << DIGIT_W) | BUF_W'(din);
            if (cnt_q != CNT_W'(PW_LEN))
                cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Buffer and count registers.
    always_ff @(posedge hz100 or posedge reset) begin
        if (reset) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

    assign q     = sr_q;
    assign count = cnt_q;

endmodule

// File: rtl/keypad_lock_fsm.sv
// Keypad combination lock: password entry, arming, code check, failed-
// attempt counting and timed lockout. Display encoding lives downstream.
module keypad_lock_fsm
    import lock_pkg::*;
#(
    parameter int PW_LEN        = DEF_PW_LEN,
    parameter int DIGIT_W       = DEF_DIGIT_W,
    parameter int MAX_FAILS     = DEF_MAX_FAILS,
    parameter int LOCKOUT_TICKS = DEF_LOCKOUT_TICKS
) (
    input  logic                                hz100,
    input  logic                                reset,
    input  logic                                key_press,
    input  logic [DIGIT_W-1:0]                  key_code,
    input  logic                                lock_cmd,
    input  logic                                clear_cmd,
    output mode_t                               mode,
    output logic [PW_LEN*DIGIT_W-1:0]           disp_digits,
    output logic [digit_cnt_w(PW_LEN)-1:0]      digit_count,
    output logic [fail_w(MAX_FAILS)-1:0]        fail_count,
    output logic [timer_w(LOCKOUT_TICKS)-1:0]   lockout_left,
    output logic                                unlock_pulse,
    output logic                                red,
    output logic                                green
);

    localparam int BUF_W  = PW_LEN * DIGIT_W;
    localparam int CNT_W  = digit_cnt_w(PW_LEN);
    localparam int FAIL_W = fail_w(MAX_FAILS);
    localparam int TMR_W  = timer_w(LOCKOUT_TICKS);

    logic              key_q;
    logic              key_evt;
    mode_t             mode_q, mode_d;
    logic [FAIL_W-1:0] fail_q, fail_d;
    logic [TMR_W-1:0]  left_q, left_d;
    logic              unlock_q, unlock_d;
    logic              red_q, red_d;
    logic              green_q, green_d;

    logic              pw_shift, pw_clr, ent_shift, ent_clr;
    logic [BUF_W-1:0]  pw_buf, ent_buf;
    logic [CNT_W-1:0]  pw_cnt, ent_cnt;

    // A held key produces a single event on its rising edge.
    assign key_evt = key_press & ~key_q;

    lock_shreg #(.PW_LEN(PW_LEN), .DIGIT_W(DIGIT_W)) u_pw (
        .hz100 (hz100),
        .reset (reset),
        .shift (pw_shift),
        .clear (pw_clr),
        .din   (key_code),
        .q     (pw_buf),
        .count (pw_cnt)
    );

    lock_shreg #(.PW_LEN(PW_LEN), .DIGIT_W(DIGIT_W)) u_ent (
        .hz100 (hz100),
        .reset (reset),
        .shift (ent_shift),
        .clear (ent_clr),
        .din   (key_code),
        .q     (ent_buf),
        .count (ent_cnt)
    );

    // Next-state logic; lock_cmd > clear_cmd > key_evt, losers are dropped.
    always_comb begin
        mode_d    = mode_q;
        fail_d    = fail_q;
        left_d    = left_q;
        unlock_d  = 1'b0;
        pw_shift  = 1'b0;
        pw_clr    = 1'b0;
        ent_shift = 1'b0;
        ent_clr   = 1'b0;
        unique case (mode_q)
            EDIT: begin
                if (lock_cmd) begin
                    // Arming needs a complete password; otherwise ignored.
                    if (pw_cnt == CNT_W'(PW_LEN)) begin
                        mode_d  = LOCKED;
                        ent_clr = 1'b1;
                    end
                end else if (clear_cmd) begin
                    pw_clr = 1'b1;
                end else if (key_evt) begin
                    pw_shift = 1'b1;
                end
            end
            LOCKED: begin
                if (lock_cmd) begin
                    // Already armed: swallow the command and anything below it.
                end else if (clear_cmd) begin
                    ent_clr = 1'b1;
                end else if (key_evt) begin
                    ent_shift = 1'b1;
                    if (ent_cnt == CNT_W'(PW_LEN - 1))
                        mode_d = CHECK;
                end
            end
            CHECK: begin
                ent_clr = 1'b1;
                if (ent_buf == pw_buf) begin
                    mode_d   = EDIT;
                    unlock_d = 1'b1;
                    fail_d   = '0;
                end else if (int'(fail_q) + 1 < MAX_FAILS) begin
                    mode_d = LOCKED;
                    fail_d = fail_q + FAIL_W'(1);
                end else begin
                    mode_d = LOCKOUT;
                    fail_d = FAIL_W'(MAX_FAILS);
                    left_d = TMR_W'(LOCKOUT_TICKS);
                end
            end
            LOCKOUT: begin
                if (left_q == TMR_W'(1)) begin
                    mode_d  = LOCKED;
                    left_d  = '0;
                    fail_d  = '0;
                    ent_clr = 1'b1;
                end else if (left_q != '0) begin
                    left_d = left_q - TMR_W'(1);
                end
            end
            default: mode_d = EDIT;
        endcase
        red_d   = (mode_d != EDIT);
        green_d = (mode_d == EDIT);
    end

    // FSM state, counters and registered outputs.
    always_ff @(posedge hz100 or posedge reset) begin
        if (reset) begin
            key_q    <= 1'b0;
            mode_q   <= EDIT;
            fail_q   <= '0;
            left_q   <= '0;
            unlock_q <= 1'b0;
            red_q    <= 1'b0;
            green_q  <= 1'b1;
        end else begin
            key_q    <= key_press;
            mode_q   <= mode_d;
            fail_q   <= fail_d;
            left_q   <= left_d;
            unlock_q <= unlock_d;
            red_q    <= red_d;
            green_q  <= green_d;
        end
    end

    // Display source follows the mode; lockout blanks the digits.
    always_comb begin
        disp_digits = '0;
        digit_count = '0;
        unique case (mode_q)
            EDIT: begin
                disp_digits = pw_buf;
                digit_count = pw_cnt;
            end
            LOCKED, CHECK: begin
                disp_digits = ent_buf;
                digit_count = ent_cnt;
            end
            default: begin
                disp_digits = '0;
                digit_count = '0;
            end
        endcase
    end

    assign mode         = mode_q;
    assign fail_count   = fail_q;
    assign lockout_left = left_q;
    assign unlock_pulse = unlock_q;
    assign red          = red_q;
    assign green        = green_q;

endmodule
